// File: rtl/time_seq_pkg.sv
// Shared constants, BCD time bundle and
// mode-dependent reset/legality helpers.
package time_seq_pkg;

  localparam logic [3:0] DIG_H10 = 4'b1000;
  localparam logic [3:0] DIG_H1  = 4'b0100;
  localparam logic [3:0] DIG_M10 = 4'b0010;
  localparam logic [3:0] DIG_M1  = 4'b0001;

  localparam logic [3:0] MIN1_MAX  = 4'd9;
  localparam logic [2:0] MIN10_MAX = 3'd5;

  localparam logic [1:0] H10_RST_12 = 2'd1;
  localparam logic [3:0] H1_RST_12  = 4'd2;
  localparam logic [1:0] H10_RST_24 = 2'd0;
  localparam logic [3:0] H1_RST_24  = 4'd0;

  typedef struct packed {
    logic [1:0] hour10;
    logic [3:0] hour1;
    logic [2:0] min10;
    logic [3:0] min1;
  } bcd_time_t;

  function automatic bcd_time_t reset_time(
    input logic mode24
  );
    bcd_time_t t;
    t.hour10 = mode24 ? H10_RST_24 : H10_RST_12;
    t.hour1  = mode24 ? H1_RST_24 : H1_RST_12;
    t.min10  = '0;
    t.min1   = '0;
    return t;
  endfunction

  function automatic logic time_legal(
    input bcd_time_t t,
    input logic      mode24
  );
    logic ok;
    ok = (t.min1 <= MIN1_MAX) &&
         (t.min10 <= MIN10_MAX) &&
         (t.hour1 <= 4'd9);
    if (mode24)
      ok = ok && ((t.hour10 < 2'd2) ||
                  (t.hour10 == 2'd2 &&
                   t.hour1 <= 4'd3));
    else
      ok = ok && ((t.hour10 == 2'd0 &&
                   t.hour1 != 4'd0) ||
                  (t.hour10 == 2'd1 &&
                   t.hour1 <= 4'd2));
    return ok;
  endfunction

endpackage

// File: rtl/time_sequencer_bcd_wrap_counter.sv
// Wrapping BCD digit counter with load and
// carry-out, used for the minute digits.
module bcd_wrap_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 9,
  parameter int RESET_VAL = 0
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V =
    WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V =
    WIDTH'(RESET_VAL);

  always_ff @(posedge Clock) begin
    if (!nReset)
      value <= RST_V;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= (value >= MAX_V) ? '0
             : value + WIDTH'(1);
  end

  assign carry = inc & (value == MAX_V);

endmodule

// File: rtl/time_sequencer.sv
// BCD hour/minute sequencer with 12/24h mode
// and a multiplexed 4-digit display scan.
module time_sequencer
  import time_seq_pkg::*;
#(
  parameter int SCAN_DIV      = 1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Tick,
  input  logic        SyncMinIn,
  input  logic        SyncHourIn,
  input  logic        Mode24,
  input  logic        Blank,
  output logic [3:0]  D,
  output logic [3:0]  Digit,
  output logic        DP,
  output logic [13:0] TimeOut
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(SCAN_DIV - 1);

  logic          mode_q;
  logic [1:0]    h10_q;
  logic [3:0]    h1_q;
  logic [1:0]    h10_n;
  logic [3:0]    h1_n;
  logic [2:0]    m10;
  logic [3:0]    m1;
  logic          m1_cy;
  logic          m10_cy;
  logic          inc_m;
  logic          inc_h;
  logic          mode_chg;
  logic          force_rst;
  bcd_time_t     cur;
  bcd_time_t     rst_t;
  logic [3:0]    scan_q;
  logic [CW-1:0] cnt_q;
  logic          lead_blank;

  assign cur      = {h10_q, h1_q, m10, m1};
  assign rst_t    = reset_time(Mode24);
  assign mode_chg = (mode_q != Mode24);
  assign inc_m    = Tick | SyncMinIn;

  // Mode change and corrupt state both reload
  // the reset time and swallow increments.
  assign force_rst = mode_chg |
    ((inc_m | SyncHourIn) &
     ~time_legal(cur, mode_q));

  assign inc_h =
    (m10_cy & ~SyncMinIn) | SyncHourIn;

  bcd_wrap_counter #(
    .WIDTH    (4),
    .MAX      (int'(MIN1_MAX)),
    .RESET_VAL(0)
  ) u_min1 (
    .Clock   (Clock),
    .nReset  (nReset),
    .inc     (inc_m),
    .load    (force_rst),
    .load_val(rst_t.min1),
    .value   (m1),
    .carry   (m1_cy)
  );

  bcd_wrap_counter #(
    .WIDTH    (3),
    .MAX      (int'(MIN10_MAX)),
    .RESET_VAL(0)
  ) u_min10 (
    .Clock   (Clock),
    .nReset  (nReset),
    .inc     (m1_cy),
    .load    (force_rst),
    .load_val(rst_t.min10),
    .value   (m10),
    .carry   (m10_cy)
  );

  always_comb begin
    h10_n = h10_q;
    h1_n  = h1_q;
    if (!mode_q) begin
      if (h10_q == 2'd1 && h1_q == 4'd2) begin
        h10_n = 2'd0;
        h1_n  = 4'd1;
      end else if (h1_q == 4'd9) begin
        h10_n = h10_q + 2'd1;
        h1_n  = 4'd0;
      end else begin
        h1_n  = h1_q + 4'd1;
      end
    end else begin
      if (h10_q == 2'd2 && h1_q == 4'd3) begin
        h10_n = 2'd0;
        h1_n  = 4'd0;
      end else if (h1_q == 4'd9) begin
        h10_n = h10_q + 2'd1;
        h1_n  = 4'd0;
      end else begin
        h1_n  = h1_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      mode_q <= Mode24;
      h10_q  <= rst_t.hour10;
      h1_q   <= rst_t.hour1;
    end else begin
      mode_q <= Mode24;
      if (force_rst) begin
        h10_q <= rst_t.hour10;
        h1_q  <= rst_t.hour1;
      end else if (inc_h) begin
        h10_q <= h10_n;
        h1_q  <= h1_n;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      scan_q <= DIG_H10;
      cnt_q  <= '0;
    end else if (!$onehot(scan_q)) begin
      scan_q <= DIG_H10;
      cnt_q  <= '0;
    end else if (cnt_q >= LAST) begin
      scan_q <= {scan_q[0], scan_q[3:1]};
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    D  = '0;
    DP = 1'b1;
    unique case (1'b1)
      scan_q[3]: D = {2'b00, h10_q};
      scan_q[2]: begin
        D  = h1_q;
        DP = 1'b0;
      end
      scan_q[1]: D = {1'b0, m10};
      scan_q[0]: D = m1;
      default: ;
    endcase
  end

  assign lead_blank = BLANK_LEADING &&
    !Mode24 && (h10_q == 2'd0) && scan_q[3];

  assign Digit = (Blank | lead_blank) ? 4'b0000
               : scan_q;

  assign TimeOut = {1'b0, cur};

endmodule
